// File: rtl/i2s_frame_scheduler.sv
// Frame FIFO between an upstream sample source and an I2S encoder, popping one
// stereo frame per word-clock boundary. Optional define I2S_SCHED_HOLD_EN holds the last frame while STARVED.
module i2s_frame_scheduler #(
    parameter int DEPTH = 4,
    parameter int PRIME = 2
) (
    input  logic                       i_mclk,
    input  logic                       i_rst,
    input  logic                       i_enable,
    input  logic                       i_lrclk,
    input  logic                       i_valid,
    input  logic [15:0]                i_data_l,
    input  logic [15:0]                i_data_r,
    output logic                       o_ready,
    output logic [15:0]                o_data_l,
    output logic [15:0]                o_data_r,
    output logic                       o_frame,
    output logic [1:0]                 o_state,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [7:0]                 o_underrun_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_MUTE    = 2'd0,
        S_RUN     = 2'd1,
        S_STARVED = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           lrclk_prev_q;
    logic [LW-1:0]  level_q, level_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]    mem_q [DEPTH];
    logic [31:0]    mem_d [DEPTH];
    logic [15:0]    data_l_q, data_l_d;
    logic [15:0]    data_r_q, data_r_d;
    logic [7:0]     underrun_q, underrun_d;

    logic boundary;
    logic ready;
    logic push;
    logic pop;

    assign boundary = lrclk_prev_q & ~i_lrclk;
    assign ready    = i_enable & (level_q < LW'(DEPTH));
    assign push     = i_valid & ready;

    // Scheduler FSM: decisions are taken only in boundary cycles; disable overrides all.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        data_l_d   = data_l_q;
        data_r_d   = data_r_q;
        underrun_d = underrun_q;
        if (!i_enable) begin
            state_d = S_MUTE;
            if (boundary) begin
                data_l_d = '0;
                data_r_d = '0;
            end
        end else if (boundary) begin
            case (state_q)
                S_MUTE: begin
                    if (level_q >= LW'(PRIME)) begin
                        state_d = S_RUN;
                        pop     = 1'b1;
                    end else begin
                        data_l_d = '0;
                        data_r_d = '0;
                    end
                end
                S_RUN: begin
                    if (level_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_STARVED;
                        if (underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;
`ifndef I2S_SCHED_HOLD_EN
                        data_l_d = '0;
                        data_r_d = '0;
`endif
                    end
                end
                S_STARVED: begin
                    if (level_q >= LW'(PRIME)) begin
                        state_d = S_RUN;
                        pop     = 1'b1;
                    end else begin
`ifdef I2S_SCHED_HOLD_EN
                        data_l_d = data_l_q;
                        data_r_d = data_r_q;
`else
                        data_l_d = '0;
                        data_r_d = '0;
`endif
                    end
                end
                default: begin
                    state_d  = S_MUTE;
                    data_l_d = '0;
                    data_r_d = '0;
                end
            endcase
        end
        if (pop) begin
            data_l_d = mem_q[rd_ptr_q][31:16];
            data_r_d = mem_q[rd_ptr_q][15:0];
        end
    end

    // FIFO bookkeeping; pointer width equals log2(DEPTH) so wrap is implicit.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {i_data_l, i_data_r};
        if (!i_enable) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            level_d  = level_q + LW'(push) - LW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end
    end

    always_ff @(posedge i_mclk) begin
        if (i_rst) begin
            state_q      <= S_MUTE;
            lrclk_prev_q <= 1'b0;
            level_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            data_l_q     <= '0;
            data_r_q     <= '0;
            underrun_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            lrclk_prev_q <= i_lrclk;
            level_q      <= level_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_l_q     <= data_l_d;
            data_r_q     <= data_r_d;
            underrun_q   <= underrun_d;
            mem_q        <= mem_d;
        end
    end

    assign o_ready        = ready;
    assign o_data_l       = data_l_q;
    assign o_data_r       = data_r_q;
    assign o_frame        = boundary;
    assign o_state        = state_q;
    assign o_level        = level_q;
    assign o_underrun_cnt = underrun_q;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Scoreboard bench for i2s_frame_scheduler: expected per-boundary outputs are queued
// by the stimulus and checked by an independent monitor one edge after each o_frame.
module tb_i2s_frame_scheduler;

    logic        i_mclk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_lrclk = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_data_l = '0;
    logic [15:0] i_data_r = '0;
    logic        o_ready;
    logic [15:0] o_data_l;
    logic [15:0] o_data_r;
    logic        o_frame;
    logic [1:0]  o_state;
    logic [2:0]  o_level;
    logic [7:0]  o_underrun_cnt;

`ifdef I2S_SCHED_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    localparam logic [1:0] MUTE = 2'd0, RUN = 2'd1, STARVED = 2'd2;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_cnt  = 0;
    logic [33:0] exp_q[$];
    bit          pending  = 0;

    i2s_frame_scheduler #(.DEPTH(4), .PRIME(2)) dut (
        .i_mclk(i_mclk), .i_rst(i_rst), .i_enable(i_enable), .i_lrclk(i_lrclk),
        .i_valid(i_valid), .i_data_l(i_data_l), .i_data_r(i_data_r),
        .o_ready(o_ready), .o_data_l(o_data_l), .o_data_r(o_data_r),
        .o_frame(o_frame), .o_state(o_state), .o_level(o_level),
        .o_underrun_cnt(o_underrun_cnt)
    );

    always #5 i_mclk = ~i_mclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: one edge after each boundary the outputs must match the queued entry.
    always @(negedge i_mclk) begin
        if (pending) begin
            pending = 0;
            if (exp_q.size() == 0) check("frame_unexpected", {o_state, o_data_l, o_data_r}, 64'hDEAD);
            else check("frame_out", {o_state, o_data_l, o_data_r}, exp_q.pop_front());
        end
        if (o_frame) pending = 1;
    end

    task automatic tick();
        @(posedge i_mclk);
        #1;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        i_valid = 1'b1; i_data_l = l; i_data_r = r;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic frame(input logic [1:0] st, input logic [15:0] l, input logic [15:0] r,
                         input bit dp = 0, input logic [15:0] pl = 0, input logic [15:0] pr = 0);
        exp_q.push_back({st, l, r});
        i_lrclk = 1'b1;
        tick(); tick();
        i_lrclk = 1'b0;
        if (dp) begin i_valid = 1'b1; i_data_l = pl; i_data_r = pr; end
        tick();
        i_valid = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] starved_out(input logic [15:0] l, input logic [15:0] r);
        return HOLD ? {l, r} : 32'h0;
    endfunction

    initial begin
        logic [31:0] so;
        tick(); tick();
        i_rst = 1'b0;
        check("rst_state", o_state, MUTE);
        check("rst_level", o_level, 0);
        check("rst_data", {o_data_l, o_data_r}, 0);
        check("rst_frame", o_frame, 0);
        check("rst_underrun", o_underrun_cnt, 0);

        // Basic playback: two frames then underrun
        i_enable = 1'b1;
        tick();
        check("ready_enabled", o_ready, 1);
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        check("level_two", o_level, 2);
        frame(RUN, 16'h1111, 16'h2222);
        check("level_after_pop1", o_level, 1);
        frame(RUN, 16'h3333, 16'h4444);
        check("level_after_pop2", o_level, 0);
        so = starved_out(16'h3333, 16'h4444);
        frame(STARVED, so[31:16], so[15:0]);
        exp_cnt = 1;
        check("underrun_one", o_underrun_cnt, exp_cnt);
        check("state_starved", o_state, STARVED);

        // Fill without lrclk; fifth push refused
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                check("ready_full", o_ready, 0);
                check("level_full", o_level, 4);
            end
            push(16'hA000 + 16'(i), 16'hB000 + 16'(i));
        end
        check("level_after_refused", o_level, 4);
        check("state_hold_no_lrclk", o_state, STARVED);

        // Leave STARVED, then push on a pop boundary at level DEPTH-1
        frame(RUN, 16'hA000, 16'hB000);
        check("level_three", o_level, 3);
        frame(RUN, 16'hA001, 16'hB001, 1, 16'hA005, 16'hB005);
        check("level_push_pop", o_level, 3);
        frame(RUN, 16'hA002, 16'hB002);
        frame(RUN, 16'hA003, 16'hB003);
        frame(RUN, 16'hA005, 16'hB005);
        check("level_drained", o_level, 0);
        so = starved_out(16'hA005, 16'hB005);
        frame(STARVED, so[31:16], so[15:0]);
        exp_cnt = 2;
        check("underrun_two", o_underrun_cnt, exp_cnt);

        // Disable mid-frame with level 3 in RUN
        for (int i = 0; i < 4; i++) push(16'hC000 + 16'(i), 16'hD000 + 16'(i));
        frame(RUN, 16'hC000, 16'hD000);
        check("level_pre_disable", o_level, 3);
        exp_q.push_back({MUTE, 32'h0});
        i_lrclk = 1'b1;
        tick();
        i_enable = 1'b0;
        tick();
        check("disable_level", o_level, 0);
        check("disable_state", o_state, MUTE);
        check("disable_ready", o_ready, 0);
        check("disable_data_held", {o_data_l, o_data_r}, {16'hC000, 16'hD000});
        i_lrclk = 1'b0;
        tick(); tick();
        check("disable_underrun_kept", o_underrun_cnt, exp_cnt);
        i_enable = 1'b1;
        tick();

        // Force 300 underruns; counter saturates
        for (int i = 0; i < 300; i++) begin
            push(16'(i), 16'(i) ^ 16'hFFFF);
            push(16'(i) + 16'h4000, 16'h5555);
            frame(RUN, 16'(i), 16'(i) ^ 16'hFFFF);
            frame(RUN, 16'(i) + 16'h4000, 16'h5555);
            so = starved_out(16'(i) + 16'h4000, 16'h5555);
            frame(STARVED, so[31:16], so[15:0]);
            if (exp_cnt < 255) exp_cnt++;
            check("underrun_count", o_underrun_cnt, exp_cnt);
        end
        check("underrun_saturated", o_underrun_cnt, 255);

        // Mid-frame reset with a push in flight
        push(16'hE000, 16'hF000);
        push(16'hE001, 16'hF001);
        frame(RUN, 16'hE000, 16'hF000);
        i_lrclk = 1'b1;
        tick();
        i_valid = 1'b1; i_data_l = 16'h7777; i_data_r = 16'h8888;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0; i_valid = 1'b0;
        check("mid_rst_state", o_state, MUTE);
        check("mid_rst_level", o_level, 0);
        check("mid_rst_data", {o_data_l, o_data_r}, 0);
        check("mid_rst_underrun", o_underrun_cnt, 0);
        i_lrclk = 1'b0;
        #1;
        check("no_fall_after_rst", o_frame, 0);
        tick();
        check("rst_push_discarded", o_level, 0);
        tick();
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
